// File: rtl/ft_recovery_ctrl_pkg.sv
// Shared types and widths for the fault-tolerant recovery controller.
// Optional feature macro: FT_RECOVERY_PARITY_EN (parity-protected checkpoint).
package ft_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ERR_CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    RESTORE,
    RESUME,
    FATAL
  } recovery_state_e;

endpackage

// File: rtl/ft_recovery_ctrl_if.sv
// Comparator-side and core-side signals of the recovery controller.
// master = comparator/cores environment, slave = ft_recovery_ctrl.
interface ft_recovery_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  import ft_pkg::*;

  logic                  we_i;
  logic [REG_ADDR_W-1:0] addr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  mismatch_i;
  logic                  halt_o;
  logic                  recover_we_o;
  logic [REG_ADDR_W-1:0] recover_addr_o;
  logic [DATA_WIDTH-1:0] recover_data_o;
  logic                  restore_done_o;
  logic                  fatal_o;
  logic [ERR_CNT_W-1:0]  err_count_o;

  modport master (
    output we_i, addr_i, data_i, mismatch_i,
    input  halt_o, recover_we_o, recover_addr_o, recover_data_o,
           restore_done_o, fatal_o, err_count_o
  );

  modport slave (
    input  we_i, addr_i, data_i, mismatch_i,
    output halt_o, recover_we_o, recover_addr_o, recover_data_o,
           restore_done_o, fatal_o, err_count_o
  );

endinterface

// File: rtl/ft_recovery_ctrl_shadow.sv
// Checkpoint register file: one synchronous write port, one combinational read port.
// x0 has no storage. FT_RECOVERY_PARITY_EN adds an even-parity bit per entry.
module ft_shadow_regfile
  import ft_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [REG_ADDR_W-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  parity_err
);

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  logic [DATA_WIDTH-1:0] mem_q [1:NUM_REGS-1];
  logic                  wr_ok;
  logic                  rd_ok;

  assign wr_ok = we && (waddr != '0) && (waddr <= LAST_IDX);
  assign rd_ok = (raddr != '0) && (raddr <= LAST_IDX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

`ifdef FT_RECOVERY_PARITY_EN
  // Parity bit makes the XOR of data and parity zero for a healthy entry.
  logic par_q [1:NUM_REGS-1];

  function automatic logic even_par(input logic [DATA_WIDTH-1:0] v);
    return ^v;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NUM_REGS; i++) par_q[i] <= 1'b0;
    end else if (wr_ok) begin
      par_q[waddr] <= even_par(wdata);
    end
  end
`endif

  always_comb begin
    rdata      = '0;
    parity_err = 1'b0;
    if (rd_ok) begin
      rdata = mem_q[raddr];
`ifdef FT_RECOVERY_PARITY_EN
      parity_err = even_par(mem_q[raddr]) ^ par_q[raddr];
`endif
    end
  end

endmodule

// File: rtl/ft_recovery_ctrl.sv
// Lockstep recovery controller: checkpoints agreed writes, restores both cores on mismatch.
// Optional feature macro: FT_RECOVERY_PARITY_EN (parity-checked restore escalates to FATAL).
module ft_recovery_ctrl
  import ft_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int MAX_RETRY  = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  ft_recovery_ctrl_if.slave bus
);

  localparam int                    RETRY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0]    RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  recovery_state_e       state_q, state_d;
  logic [REG_ADDR_W-1:0] idx_q, idx_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic [RETRY_W-1:0]    retry_inc;
  logic [ERR_CNT_W-1:0]  err_q, err_d;

  logic                  commit;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  parity_err;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Commits are only honoured while the cores are running normally.
  assign commit    = (state_q == IDLE) && bus.we_i && !bus.mismatch_i && (bus.addr_i != '0);
  assign retry_inc = retry_q + 1'b1;

  ft_shadow_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_shadow (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .we         (commit),
    .waddr      (bus.addr_i),
    .wdata      (bus.data_i),
    .raddr      (idx_q),
    .rdata      (rd_data),
    .parity_err (parity_err)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      retry_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mismatch_i) begin
          err_d   = sat_inc(err_q);
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIM) ? FATAL : HALT;
        end else if (commit) begin
          retry_d = '0;
        end
      end
      HALT: begin
        idx_d   = REG_ADDR_W'(1);
        state_d = RESTORE;
      end
      RESTORE: begin
        // A corrupted checkpoint entry must never reach the cores.
        if (parity_err) begin
          state_d = FATAL;
        end else if (idx_q == LAST_IDX) begin
          state_d = RESUME;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RESUME:  state_d = IDLE;
      FATAL:   state_d = FATAL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.halt_o         = (state_q != IDLE);
    bus.recover_we_o   = (state_q == RESTORE) && !parity_err;
    bus.recover_addr_o = '0;
    bus.recover_data_o = '0;
    if (bus.recover_we_o) begin
      bus.recover_addr_o = idx_q;
      bus.recover_data_o = rd_data;
    end
    bus.restore_done_o = (state_q == RESUME);
    bus.fatal_o        = (state_q == FATAL);
    bus.err_count_o    = err_q;
  end

endmodule
